tx_frame_serializer: RTL
========================

Name: tx_frame_serializer

Overview:
- Transmit-side source stage that sits directly upstream of the convolutional encoder.
- Accepts bytes over a valid/ready handshake into a small FIFO and serializes them MSB-first onto the encoder's bit input and enable.
- Appends TAIL_BITS zero bits after every FRAME_BYTES bytes so the encoder trellis returns to state 0 before the next frame; the Viterbi decoder relies on this termination.
- Provides frame start/done markers for the rx-side checker.

Parameters:
- FIFO_DEPTH, 4, number of byte entries in the input FIFO; power of 2, at least 2.
- FRAME_BYTES, 8, number of data bytes per frame; at least 1.
- TAIL_BITS, 2, number of zero flush bits appended per frame; equals constraint length minus 1; at least 1.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- data_i  input  8  byte to transmit.
- valid_i  input  1  data_i is valid.
- ready_o  output  1  FIFO can accept a byte; it is high when count < FIFO_DEPTH and rst is low.
- enc_bit_o  output  1  serial bit to the encoder data input.
- enc_en_o  output  1  encoder enable; the encoder shifts only when this is high.
- frame_start_o  output  1  one-cycle pulse coincident with the first data bit of a frame.
- frame_done_o  output  1  one-cycle pulse coincident with the last tail bit.
- busy_o  output  1  high while in DATA or TAIL.
- fifo_count_o  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset: one clock, synchronous, active-high. On a clk edge with rst=1 the FIFO is emptied and all counters are cleared, and the FSM goes to IDLE. Registered outputs after reset: enc_bit_o=0, enc_en_o=0, frame_start_o=0, frame_done_o=0, busy_o=0, fifo_count_o=0.
- Reset mid-frame: the partial frame is discarded and no tail bits are sent.
- Push and pop:
  - A push occurs on an edge where valid_i & ready_o. A push while full cannot occur because ready_o is low.
  - A pop occurs on the edge that loads the 8-bit shift register.
  - Simultaneous push and pop leaves the count unchanged. A push into an empty FIFO is not poppable until the next edge (no bypass).
- All outputs except ready_o are registered.
- FSM has three states: IDLE, DATA, TAIL.
- IDLE:
  - If the FIFO is non-empty: pop, load the shift register, and go to DATA.
  - On that same edge: enc_bit_o=byte[7], enc_en_o=1, frame_start_o=1, byte_ct=0, bit_idx=0.
  - Latency: a byte pushed at edge t into an empty, idle block appears as bit7 after edge t+1.
- DATA, with bit_idx < 7: shift; enc_bit_o=next bit; enc_en_o=1; bit_idx++.
- DATA, with bit_idx == 7:
  - If byte_ct == FRAME_BYTES-1: go to TAIL with enc_bit_o=0, enc_en_o=1, tail_ct=0.
  - Else if the FIFO is non-empty: pop, load, enc_bit_o=new byte[7], enc_en_o=1, byte_ct++, bit_idx=0. The result is a gap-free bit stream.
  - Else (underrun): enc_en_o=0, enc_bit_o=0; stay in DATA holding bit_idx=7 and byte_ct. Resume exactly as above when the FIFO becomes non-empty. No frame_start_o is issued on resume.
- TAIL:
  - Each cycle: enc_bit_o=0, enc_en_o=1, tail_ct++.
  - On the cycle tail_ct == TAIL_BITS-1, frame_done_o=1.
  - Next state: if the FIFO is non-empty, pop and start a new frame (frame_start_o=1) with no idle cycle; else go to IDLE.
- enc_en_o is 0 in IDLE. busy_o=1 in DATA and TAIL.
- Counter widths:
  - bit_idx is 3 bits.
  - byte_ct is $clog2(FRAME_BYTES) bits, minimum 1.
  - tail_ct is $clog2(TAIL_BITS) bits, minimum 1.
  - FIFO pointers wrap modulo FIFO_DEPTH.
- Every frame produces exactly 8*FRAME_BYTES+TAIL_BITS cycles with enc_en_o=1.

Test Plan:
- Reset, then push 8 bytes 0xA5,0x00,0xFF,0x3C,0x81,0x7E,0x01,0x80 back-to-back -> 66 consecutive enc_en_o=1 cycles. The stream is 10100101 ... 10000000 then 00. frame_start_o appears on the first bit, frame_done_o on the 66th bit, then IDLE with busy_o=0.
- Single push of 0xC3 into an idle block at edge t -> enc_bit_o=1 after edge t+1, then the bits 1,0,0,0,0,1,1. After those 8 bits: underrun with enc_en_o=0 and busy_o=1.
- Keep valid_i high with no pops possible (push 5 bytes while the FSM is stalled) -> ready_o drops after the 4th push and fifo_count_o=4; the 5th byte is held until a pop.
- Push 16 bytes continuously -> 132 enc_en_o cycles with no gap. The second frame_start_o occurs on cycle 67, immediately after the first frame_done_o; there are two frame_done_o pulses in total.
- Assert rst for 1 cycle after the 20th data bit of a frame -> all outputs 0 and fifo_count_o=0 next cycle; no tail bits. The next pushed byte starts a fresh frame with frame_start_o.
- Underrun between bytes 3 and 4 for 5 cycles -> exactly 5 cycles of enc_en_o=0. Byte 4 then starts at bit7 with no frame_start_o, and the total enabled-cycle count stays 66.

Source files
------------

// File: rtl/tx_frame_serializer.sv
// Byte-to-bit serializer feeding the convolutional encoder: input FIFO, MSB-first shifting,
// and TAIL_BITS zero flush bits after every FRAME_BYTES bytes to terminate the trellis.
module tx_frame_serializer #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned FRAME_BYTES = 8,
    parameter int unsigned TAIL_BITS   = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [7:0]                        data_i,
    input  logic                              valid_i,
    output logic                              ready_o,
    output logic                              enc_bit_o,
    output logic                              enc_en_o,
    output logic                              frame_start_o,
    output logic                              frame_done_o,
    output logic                              busy_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count_o
);

    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ByteW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam int unsigned TailW = (TAIL_BITS > 1) ? $clog2(TAIL_BITS) : 1;

    localparam logic [CntW-1:0]  FullCount = CntW'(FIFO_DEPTH);
    localparam logic [ByteW-1:0] LastByte  = ByteW'(FRAME_BYTES - 1);
    localparam logic [TailW-1:0] LastTail  = TailW'(TAIL_BITS - 1);

    typedef enum logic [1:0] {StIdle, StData, StTail} state_e;

    state_e             state_q;
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]    wr_ptr_q;
    logic [PtrW-1:0]    rd_ptr_q;
    logic [CntW-1:0]    count_q;
    logic [7:0]         shift_q;
    logic [2:0]         bit_idx_q;
    logic [ByteW-1:0]   byte_ct_q;
    logic [TailW-1:0]   tail_ct_q;

    logic               push;
    logic               pop;
    logic               fifo_nonempty;
    logic [7:0]         head;

    assign fifo_nonempty = (count_q != '0);
    assign head          = mem_q[rd_ptr_q];
    assign ready_o       = (count_q < FullCount) && !rst;
    assign push          = valid_i && ready_o;
    assign fifo_count_o  = count_q;

    // A pop happens exactly on the edges where the FSM loads a new byte.
    always_comb begin
        pop = 1'b0;
        case (state_q)
            StIdle:  pop = fifo_nonempty;
            StData:  pop = fifo_nonempty && (bit_idx_q == 3'd7) && (byte_ct_q != LastByte);
            StTail:  pop = fifo_nonempty && (tail_ct_q == LastTail);
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            shift_q       <= '0;
            bit_idx_q     <= '0;
            byte_ct_q     <= '0;
            tail_ct_q     <= '0;
            enc_bit_o     <= 1'b0;
            enc_en_o      <= 1'b0;
            frame_start_o <= 1'b0;
            frame_done_o  <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            frame_start_o <= 1'b0;
            frame_done_o  <= 1'b0;
            case (state_q)
                StIdle: begin
                    enc_bit_o <= 1'b0;
                    enc_en_o  <= 1'b0;
                    busy_o    <= 1'b0;
                    if (pop) begin
                        state_q       <= StData;
                        shift_q       <= head;
                        enc_bit_o     <= head[7];
                        enc_en_o      <= 1'b1;
                        frame_start_o <= 1'b1;
                        busy_o        <= 1'b1;
                        byte_ct_q     <= '0;
                        bit_idx_q     <= '0;
                    end
                end
                StData: begin
                    if (bit_idx_q != 3'd7) begin
                        shift_q   <= {shift_q[6:0], 1'b0};
                        enc_bit_o <= shift_q[6];
                        enc_en_o  <= 1'b1;
                        bit_idx_q <= bit_idx_q + 3'd1;
                    end else if (byte_ct_q == LastByte) begin
                        state_q      <= StTail;
                        enc_bit_o    <= 1'b0;
                        enc_en_o     <= 1'b1;
                        tail_ct_q    <= '0;
                        frame_done_o <= (TAIL_BITS == 1);
                    end else if (pop) begin
                        shift_q   <= head;
                        enc_bit_o <= head[7];
                        enc_en_o  <= 1'b1;
                        byte_ct_q <= byte_ct_q + ByteW'(1);
                        bit_idx_q <= '0;
                    end else begin
                        // Underrun: hold position and resume on the next available byte.
                        enc_bit_o <= 1'b0;
                        enc_en_o  <= 1'b0;
                    end
                end
                StTail: begin
                    if (tail_ct_q != LastTail) begin
                        enc_bit_o    <= 1'b0;
                        enc_en_o     <= 1'b1;
                        tail_ct_q    <= tail_ct_q + TailW'(1);
                        frame_done_o <= ((tail_ct_q + TailW'(1)) == LastTail);
                    end else if (pop) begin
                        state_q       <= StData;
                        shift_q       <= head;
                        enc_bit_o     <= head[7];
                        enc_en_o      <= 1'b1;
                        frame_start_o <= 1'b1;
                        byte_ct_q     <= '0;
                        bit_idx_q     <= '0;
                    end else begin
                        state_q   <= StIdle;
                        enc_bit_o <= 1'b0;
                        enc_en_o  <= 1'b0;
                        busy_o    <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    enc_en_o <= 1'b0;
                    busy_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule
